// File: rtl/spi_initiator.sv
// SPI mode-0 initiator for the Ascon accelerator's SPI subnode.
// Sends one left-aligned frame of up to MAX_BITS bits on mosi and captures
// the miso stream right-aligned in rx_data. sck is paced at CLK_DIV clk
// cycles per half-period so the subnode's input synchronizers see every edge.
module spi_initiator #(
   parameter int CLK_DIV  = 4,
   parameter int MAX_BITS = 136
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [7:0]          len,
   input  logic [MAX_BITS-1:0] tx_data,
   output logic                busy,
   output logic                done,
   output logic [MAX_BITS-1:0] rx_data,
   output logic                csb,
   output logic                sck,
   output logic                mosi,
   input  logic                miso
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = $clog2(MAX_BITS + 1);
   localparam logic [CW-1:0] LAST_PHASE = CW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD,
      S_GAP
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_phase;
   logic [BW-1:0]         r_bits;
   logic [MAX_BITS-1:0]   r_tx;
   logic                  r_miso_meta;
   logic                  r_miso_sync;

   logic [BW-1:0]         w_len_clamped;
   logic                  w_phase_end;

   // Clamp the requested length to the frame capacity.
   always_comb begin
      w_len_clamped = BW'(len);
      if (int'(len) > MAX_BITS) begin
         w_len_clamped = BW'(MAX_BITS);
      end
   end

   assign w_phase_end = (r_phase == LAST_PHASE);

   // Two-flop synchronizer bringing the asynchronous miso into the clk domain.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value;
      // blocking here would collapse the two synchronizer stages into one.
      if (rst) begin
         r_miso_meta <= 1'b0;
         r_miso_sync <= 1'b0;
      end else begin
         r_miso_meta <= miso;
         r_miso_sync <= r_miso_meta;
      end
   end

   // Frame sequencer: phase timing, shifting and all registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_bits  <= '0;
         r_tx    <= '0;
         csb     <= 1'b1;
         sck     <= 1'b0;
         mosi    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         // NOTE: rx_data is an ordinary register, not a memory, and the host
         // relies on it reading zero after reset, so it is reset explicitly.
         rx_data <= '0;
      end else begin
         done <= 1'b0;
         if (r_state != S_IDLE) begin
            r_phase <= w_phase_end ? '0 : r_phase + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (start && (len != 8'd0)) begin
                  r_state <= S_SETUP;
                  r_phase <= '0;
                  r_tx    <= tx_data;
                  r_bits  <= w_len_clamped;
                  rx_data <= '0;
                  csb     <= 1'b0;
                  busy    <= 1'b1;
                  mosi    <= tx_data[MAX_BITS-1];
               end
            end

            S_SETUP: begin
               if (w_phase_end) begin
                  r_state <= S_HIGH;
                  sck     <= 1'b1;
               end
            end

            S_HIGH: begin
               if (w_phase_end) begin
                  rx_data <= {rx_data[MAX_BITS-2:0], r_miso_sync};
                  r_bits  <= r_bits - 1'b1;
                  sck     <= 1'b0;
                  if (r_bits > BW'(1)) begin
                     r_state <= S_LOW;
                     r_tx    <= r_tx << 1;
                     mosi    <= r_tx[MAX_BITS-2];
                  end else begin
                     r_state <= S_HOLD;
                     mosi    <= 1'b0;
                  end
               end
            end

            S_LOW: begin
               if (w_phase_end) begin
                  r_state <= S_HIGH;
                  sck     <= 1'b1;
               end
            end

            S_HOLD: begin
               if (w_phase_end) begin
                  r_state <= S_GAP;
                  csb     <= 1'b1;
               end
            end

            S_GAP: begin
               if (w_phase_end) begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/spi_initiator.md
# spi_initiator

SPI mode-0 initiator (controller) that drives the `csb`/`sck`/`mosi` pins of the Ascon accelerator's SPI subnode and captures its `miso` stream. It sits on the host/test-harness side of the link, in its own clock domain. It paces `sck` slowly enough that the subnode's 2-flop input synchronizers sample every edge. A host issues one start pulse with a bit count and a left-aligned payload, and receives a done pulse with the captured response.

## Interface
Parameters:
- `CLK_DIV`, default 4: clk cycles per `sck` half-period and per CS setup/hold/gap phase; legal minimum is 4.
- `MAX_BITS`, default 136: frame capacity (8-bit command + 128-bit register).

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request; honoured only in IDLE with `len != 0`.
- `len` input 8: number of bits in the frame; values above MAX_BITS are clamped to MAX_BITS.
- `tx_data` input MAX_BITS: payload, left-aligned; bit MAX_BITS-1 is sent first.
- `busy` output 1: high while a frame is in progress.
- `done` output 1: one-cycle pulse when the frame completes; `rx_data` is valid from this cycle.
- `rx_data` output MAX_BITS: captured bits, right-aligned; the last bit received is at bit 0 and unused upper bits are 0.
- `csb` output 1: chip select, active low.
- `sck` output 1: serial clock, idle low.
- `mosi` output 1: serial data out.
- `miso` input 1: serial data in, asynchronous to `clk`.

## Operation
- `miso` passes through an internal 2-flop synchronizer (reset value 0) before sampling.
- The FSM has the states IDLE, SETUP, HIGH, LOW, HOLD and GAP. A phase counter counts CLK_DIV cycles per state. A bit counter holds the remaining bits.
- **IDLE:** `csb`=1, `sck`=0, `mosi`=0, `busy`=0.
  - On `start && len!=0`: latch `tx_data` into the TX shifter, latch the clamped `len`, clear `rx_data`, and go to SETUP.
  - `start` with `len==0` is ignored.
- **SETUP:** `csb`=0, `sck`=0, `mosi`=TX MSB. After CLK_DIV cycles, go to HIGH.
- **HIGH:** `sck`=1.
  - On the last cycle of the phase, shift the synchronized `miso` into `rx_data` bit 0 (the existing bits move up one position) and decrement the bit counter.
  - If bits remain, go to LOW; otherwise go to HOLD.
- **LOW:** `sck`=0. On entry, shift the TX register and drive `mosi` with the next bit. After CLK_DIV cycles, go to HIGH.
- **HOLD:** `csb`=0, `sck`=0, `mosi`=0 for CLK_DIV cycles.
- **GAP:** `csb`=1, `sck`=0 for CLK_DIV cycles (minimum deselect time), then go to IDLE and pulse `done`.
- All outputs are registered. `sck` makes exactly `len` rising edges per frame. `mosi` changes only while `sck`=0.
- `start` while `busy` is ignored; the in-flight frame is unaffected. `tx_data` and `len` may change after acceptance without effect.
- `rx_data` holds its value after `done` until the next accepted start.
- **Reset:** on the cycle after `rst` is sampled high, from any state:
  - `csb`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, FSM in IDLE.
  - Reset during a frame aborts it with no `done` pulse; the subnode sees `csb` rise.

## Timing
- `start` is sampled in cycle 0. `busy`=1 and `csb`=0 from cycle 1.
- Busy length: D·(2·len+2) cycles, where D=CLK_DIV. This is the sum of SETUP D, len·D HIGH, (len−1)·D LOW, HOLD D and GAP D.
- `done`=1 and `busy`=0 in cycle D·(2·len+2)+1. A new `start` is accepted in that same cycle.
- First `sck` rise occurs in cycle D+1. Each bit takes 2·D cycles.
- `miso` is sampled D−1 cycles after `sck` rises. With the 2-flop synchronizer, the effective sample point is 2 cycles earlier. Requirement: the subnode must settle `miso` within D cycles of the `sck` fall.

## Test plan
- **Loopback, D=4, len=8:** `mosi` tied to `miso`, `tx_data[135:128]`=0xA5, start → busy for exactly 72 cycles, 8 `sck` rises, `done` at cycle 73, `rx_data`=0x…00A5.
- **Full frame, len=136:** `tx_data`=alternating 0xAA…, `miso` tied high → `rx_data`=all 136 ones, `mosi` pattern 1,0,1,0… sampled at each `sck` rise, busy 1096 cycles.
- **Clamp and ignore:** len=200 → behaves exactly as len=136; len=0 with start → `busy` stays 0, no `done`, outputs unchanged.
- **Start while busy:** pulse `start` with new data mid-frame → the original frame completes unchanged, with only one `done`.
- **Reset mid-frame:** assert `rst` during bit 5 → next cycle `csb`=1, `sck`=0, `busy`=0, `rx_data`=0, no `done`; a subsequent len=8 loopback returns the correct byte.
- **Against the Ascon subnode:** connect to the accelerator top (`uio_in[0]`=`csb`, `[1]`=`mosi`, `[3]`=`sck`, `uio_out[2]`=`miso`) with a shared clk and D=4. Write a 128-bit register, then read it back → the read data equals the written value.
